// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter: I-fetch vs load/store, with an in-order owner queue
// that routes responses back and drops flushed I responses.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PTR_WIDTH  = 2,
  parameter int unsigned STREAK_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic                    i_flush,
  output logic                    i_rvalid,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic                    d_valid,
  output logic                    d_ready,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic                    d_wen,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wmask,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_wen,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int unsigned Depth   = 1 << PTR_WIDTH;
  localparam int unsigned StreakW = $clog2(STREAK_MAX + 1);
  localparam logic [PTR_WIDTH-1:0] MaxCount  = PTR_WIDTH'(Depth - 1);
  localparam logic [StreakW-1:0]   StreakMax = StreakW'(STREAK_MAX);
  localparam logic OwnI = 1'b0;
  localparam logic OwnD = 1'b1;

  logic [Depth-1:0]     owner_q, owner_d, discard_q, discard_d;
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic                 locked_q, locked_d, lock_owner_q, lock_owner_d;
  logic [StreakW-1:0]   streak_q, streak_d;

  logic full, empty, grant, push, pop, head_owner, head_discard;

  always_comb begin
    full         = (count_q == MaxCount);
    empty        = (count_q == '0);
    head_owner   = owner_q[rd_ptr_q];
    head_discard = discard_q[rd_ptr_q];
    if (locked_q) begin
      grant = lock_owner_q;
    end else begin
      grant = (d_valid && (!i_valid || streak_q < StreakMax)) ? OwnD : OwnI;
    end

    mem_valid = !rst && !full && (locked_q || i_valid || d_valid);
    push      = mem_valid && mem_ready;
    pop       = !rst && mem_rvalid && !empty;
    i_ready   = !rst && mem_ready && !full && (grant == OwnI);
    d_ready   = !rst && mem_ready && !full && (grant == OwnD);

    mem_addr  = (grant == OwnD) ? d_addr : i_addr;
    mem_wen   = (grant == OwnD) && d_wen;
    mem_wdata = (grant == OwnD) ? d_wdata : '0;
    mem_wmask = (grant == OwnD) ? d_wmask : '0;

    i_rvalid = pop && (head_owner == OwnI) && !head_discard && !i_flush;
    d_rvalid = pop && (head_owner == OwnD);
    i_rdata  = mem_rdata;
    d_rdata  = mem_rdata;
  end

  always_comb begin
    owner_d   = owner_q;
    discard_d = discard_q;
    // Marking every I-owned slot is safe: stale slots get rewritten on push.
    if (i_flush) begin
      discard_d = discard_q | ~owner_q;
    end
    if (push) begin
      owner_d[wr_ptr_q]   = grant;
      discard_d[wr_ptr_q] = (grant == OwnI) && i_flush;
    end
    wr_ptr_d = wr_ptr_q + PTR_WIDTH'(push);
    rd_ptr_d = rd_ptr_q + PTR_WIDTH'(pop);
    case ({push, pop})
      2'b10:   count_d = count_q + PTR_WIDTH'(1);
      2'b01:   count_d = count_q - PTR_WIDTH'(1);
      default: count_d = count_q;
    endcase

    locked_d     = mem_valid && !mem_ready;
    lock_owner_d = grant;
    if (i_flush && (grant == OwnI)) begin
      locked_d = 1'b0;
    end

    streak_d = streak_q;
    if (push && (grant == OwnD) && i_valid) begin
      streak_d = (streak_q == StreakMax) ? streak_q : streak_q + StreakW'(1);
    end else if ((push && (grant == OwnI)) || !i_valid) begin
      streak_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= '0;
      discard_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      locked_q     <= 1'b0;
      lock_owner_q <= OwnI;
      streak_q     <= '0;
    end else begin
      owner_q      <= owner_d;
      discard_q    <= discard_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      locked_q     <= locked_d;
      lock_owner_q <= lock_owner_d;
      streak_q     <= streak_d;
    end
  end

  // A response with nothing outstanding is a protocol error on the memory side.
  rvalid_when_empty: assert property (@(posedge clk) disable iff (rst) !(mem_rvalid && empty));

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid, i_ready, i_flush, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_valid, d_ready, d_wen, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [MW-1:0] d_wmask;
  logic          mem_valid, mem_ready, mem_wen, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [MW-1:0] mem_wmask;

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PTR_WIDTH(2), .STREAK_MAX(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_flush(i_flush),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wen(d_wen),
    .d_wdata(d_wdata), .d_wmask(d_wmask), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_valid = 0; i_addr = '0; i_flush = 0;
    d_valid = 0; d_addr = '0; d_wen = 0; d_wdata = '0; d_wmask = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    i_valid = 1; d_valid = 1; mem_ready = 1; mem_rvalid = 1;
    @(negedge clk);
    n_cmp++; if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mem_valid: got %b want 0", mem_valid); end
    n_cmp++; if (i_ready !== 1'b0) begin n_bad++; $display("FAIL rst_i_ready: got %b want 0", i_ready); end
    n_cmp++; if (d_ready !== 1'b0) begin n_bad++; $display("FAIL rst_d_ready: got %b want 0", d_ready); end
    n_cmp++; if ({i_rvalid, d_rvalid} !== 2'b00) begin n_bad++; $display("FAIL rst_rvalid: got %b%b want 00", i_rvalid, d_rvalid); end
    tick();
    rst = 0;
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL idle_mem_valid: got %b want 0", mem_valid); end
    tick();
  endtask

  task automatic test_i_only();
    do_reset();
    mem_ready = 1;
    for (int k = 0; k < 4; k++) begin
      i_valid = (k < 3);
      i_addr = 32'h100 + 32'(4 * k);
      mem_rvalid = (k > 0);
      mem_rdata = 32'hA0A0_0000 + 32'(k - 1);
      @(negedge clk);
      if (k < 3) begin
        n_cmp++; if (i_ready !== 1'b1) begin n_bad++; $display("FAIL ionly_i_ready[%0d]: got %b want 1", k, i_ready); end
        n_cmp++; if (mem_addr !== i_addr) begin n_bad++; $display("FAIL ionly_addr[%0d]: got %h want %h", k, mem_addr, i_addr); end
        n_cmp++; if ({mem_wen, mem_wmask} !== 5'b0) begin n_bad++; $display("FAIL ionly_wen_mask[%0d]: got %b want 0", k, {mem_wen, mem_wmask}); end
      end
      if (k > 0) begin
        n_cmp++; if (i_rvalid !== 1'b1 || i_rdata !== mem_rdata) begin n_bad++; $display("FAIL ionly_resp[%0d]: got %b/%h want 1/%h", k, i_rvalid, i_rdata, mem_rdata); end
      end
      n_cmp++; if (d_rvalid !== 1'b0) begin n_bad++; $display("FAIL ionly_d_rvalid[%0d]: got %b want 0", k, d_rvalid); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_fairness();
    bit g [11];
    do_reset();
    mem_ready = 1;
    for (int k = 0; k <= 10; k++) begin
      g[k] = (k % 5 != 4);  // 1 = D expected
      i_valid = (k < 10); d_valid = (k < 10);
      i_addr = 32'h1000 + 32'(k); d_addr = 32'h2000 + 32'(k);
      mem_rvalid = (k > 0);
      mem_rdata = 32'hB000 + 32'(k);
      @(negedge clk);
      if (k < 10) begin
        n_cmp++; if ({d_ready, i_ready} !== {g[k], !g[k]}) begin n_bad++; $display("FAIL fair_grant[%0d]: got d%b i%b want d%b", k, d_ready, i_ready, g[k]); end
        n_cmp++; if (mem_addr !== (g[k] ? d_addr : i_addr)) begin n_bad++; $display("FAIL fair_addr[%0d]: got %h", k, mem_addr); end
      end
      if (k > 0) begin
        n_cmp++; if ({d_rvalid, i_rvalid} !== {g[k-1], !g[k-1]}) begin n_bad++; $display("FAIL fair_route[%0d]: got d%b i%b want d%b", k, d_rvalid, i_rvalid, g[k-1]); end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_lock();
    do_reset();
    d_valid = 1; d_addr = 32'hD0; d_wen = 1; d_wdata = 32'h1234_5678; d_wmask = 4'hA;
    for (int k = 0; k < 4; k++) begin
      mem_ready = (k == 3);
      i_valid = (k >= 1); i_addr = 32'h1A0;
      @(negedge clk);
      n_cmp++; if (mem_addr !== 32'hD0 || mem_wen !== 1'b1 || mem_wmask !== 4'hA) begin n_bad++; $display("FAIL lockd_fields[%0d]: got %h/%b/%h want d0/1/a", k, mem_addr, mem_wen, mem_wmask); end
      n_cmp++; if ({d_ready, i_ready} !== {(k == 3), 1'b0}) begin n_bad++; $display("FAIL lockd_ready[%0d]: got d%b i%b want d%b i0", k, d_ready, i_ready, (k == 3)); end
      tick();
    end
    do_reset();
    i_valid = 1; i_addr = 32'h2A0;
    for (int k = 0; k < 3; k++) begin
      mem_ready = (k == 2);
      d_valid = (k >= 1); d_addr = 32'hD4;
      @(negedge clk);
      n_cmp++; if (mem_addr !== 32'h2A0) begin n_bad++; $display("FAIL locki_addr[%0d]: got %h want 2a0", k, mem_addr); end
      n_cmp++; if ({i_ready, d_ready} !== {(k == 2), 1'b0}) begin n_bad++; $display("FAIL locki_ready[%0d]: got i%b d%b want i%b d0", k, i_ready, d_ready, (k == 2)); end
      tick();
    end
    i_valid = 0;
    @(negedge clk);
    n_cmp++; if (d_ready !== 1'b1) begin n_bad++; $display("FAIL locki_after: got d_ready %b want 1", d_ready); end
    tick();
    idle_inputs();
  endtask

  task automatic test_full();
    do_reset();
    d_valid = 1; mem_ready = 1;
    tick(); tick();
    do_reset();  // two entries outstanding are dropped here
    for (int k = 0; k < 6; k++) begin
      d_valid = 1; d_addr = 32'h300 + 32'(k < 3 ? k : 3);
      i_valid = (k >= 3); i_addr = 32'h400;
      mem_ready = 1;
      mem_rvalid = (k == 4); mem_rdata = 32'hC0DE;
      @(negedge clk);
      if (k < 3 || k == 5) begin
        n_cmp++; if (d_ready !== 1'b1 || mem_addr !== d_addr) begin n_bad++; $display("FAIL full_accept[%0d]: got %b/%h want 1/%h", k, d_ready, mem_addr, d_addr); end
      end else begin
        n_cmp++; if ({mem_valid, d_ready, i_ready} !== 3'b000) begin n_bad++; $display("FAIL full_block[%0d]: got %b want 000", k, {mem_valid, d_ready, i_ready}); end
      end
      if (k == 4) begin
        n_cmp++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hC0DE) begin n_bad++; $display("FAIL full_pop: got %b/%h want 1/c0de", d_rvalid, d_rdata); end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    mem_ready = 1;
    for (int k = 0; k < 3; k++) begin
      i_valid = (k != 1); d_valid = (k == 1);
      tick();
    end
    idle_inputs();
    i_flush = 1;
    tick();
    i_flush = 0;
    for (int k = 0; k < 3; k++) begin
      mem_rvalid = 1; mem_rdata = 32'hF0 + 32'(k);
      @(negedge clk);
      n_cmp++; if ({i_rvalid, d_rvalid} !== {1'b0, (k == 1)}) begin n_bad++; $display("FAIL flush_resp[%0d]: got i%b d%b want i0 d%b", k, i_rvalid, d_rvalid, (k == 1)); end
      tick();
    end
    mem_rvalid = 0;
    for (int k = 0; k < 4; k++) begin
      d_valid = 1; mem_ready = 1;
      @(negedge clk);
      n_cmp++; if (d_ready !== (k < 3)) begin n_bad++; $display("FAIL flush_empty[%0d]: got %b want %b", k, d_ready, (k < 3)); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_flush_collision();
    do_reset();
    mem_ready = 1; i_valid = 1; i_addr = 32'h500;
    tick();
    i_addr = 32'h504; i_flush = 1; mem_rvalid = 1; mem_rdata = 32'h5A;
    @(negedge clk);
    n_cmp++; if (i_ready !== 1'b1) begin n_bad++; $display("FAIL coll_i_ready: got %b want 1", i_ready); end
    n_cmp++; if (i_rvalid !== 1'b0) begin n_bad++; $display("FAIL coll_i_rvalid: got %b want 0", i_rvalid); end
    tick();
    i_valid = 0; i_flush = 0; mem_rvalid = 1;
    @(negedge clk);
    n_cmp++; if ({i_rvalid, d_rvalid} !== 2'b00) begin n_bad++; $display("FAIL coll_silent: got %b%b want 00", i_rvalid, d_rvalid); end
    tick();
    mem_rvalid = 0; i_valid = 1; i_addr = 32'h508;
    tick();
    i_valid = 0; mem_rvalid = 1; mem_rdata = 32'h77;
    @(negedge clk);
    n_cmp++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h77) begin n_bad++; $display("FAIL coll_next: got %b/%h want 1/77", i_rvalid, i_rdata); end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    bit mq_owner[$];  // 1 = D
    bit mq_disc[$];
    int m_streak = 0;
    bit m_locked = 0, m_lock_owner = 0;
    bit ih = 0, dh = 0;
    bit full, g, e_mv, pop, hs, e_irv, e_drv;
    do_reset();
    for (int c = 0; c < 500; c++) begin
      if (!ih) begin i_valid = 1'($urandom_range(0, 1)); i_addr = $urandom; end
      if (!dh) begin
        d_valid = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wen = 1'($urandom_range(0, 1));
        d_wdata = $urandom; d_wmask = MW'($urandom);
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      mem_rvalid = (mq_owner.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_rdata = $urandom;
      i_flush = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      full = (mq_owner.size() == 3);
      g = m_locked ? m_lock_owner : (d_valid && (!i_valid || m_streak < 4));
      e_mv = !full && (m_locked || i_valid || d_valid);
      pop = mem_rvalid;
      e_irv = pop && !mq_owner[0] && !mq_disc[0] && !i_flush;
      e_drv = pop && mq_owner[0];
      n_cmp++; if (mem_valid !== e_mv) begin n_bad++; $display("FAIL rnd_mem_valid[%0d]: got %b want %b", c, mem_valid, e_mv); end
      n_cmp++; if ({i_ready, d_ready} !== {mem_ready && !full && !g, mem_ready && !full && g}) begin n_bad++; $display("FAIL rnd_ready[%0d]: got i%b d%b grantD %b", c, i_ready, d_ready, g); end
      n_cmp++; if ({i_rvalid, d_rvalid} !== {e_irv, e_drv}) begin n_bad++; $display("FAIL rnd_rvalid[%0d]: got i%b d%b want i%b d%b", c, i_rvalid, d_rvalid, e_irv, e_drv); end
      if (e_mv) begin
        n_cmp++; if (mem_addr !== (g ? d_addr : i_addr) || mem_wen !== (g && d_wen)) begin n_bad++; $display("FAIL rnd_req[%0d]: got %h/%b grantD %b", c, mem_addr, mem_wen, g); end
      end
      if (e_drv) begin
        n_cmp++; if (d_rdata !== mem_rdata) begin n_bad++; $display("FAIL rnd_d_rdata[%0d]: got %h want %h", c, d_rdata, mem_rdata); end
      end
      hs = e_mv && mem_ready;
      if (pop) begin void'(mq_owner.pop_front()); void'(mq_disc.pop_front()); end
      if (i_flush) foreach (mq_disc[j]) if (!mq_owner[j]) mq_disc[j] = 1;
      if (hs) begin mq_owner.push_back(g); mq_disc.push_back(!g && i_flush); end
      if (hs && g && i_valid) m_streak = (m_streak < 4) ? m_streak + 1 : 4;
      else if ((hs && !g) || !i_valid) m_streak = 0;
      m_locked = e_mv && !mem_ready && !(i_flush && !g);
      m_lock_owner = g;
      ih = i_valid && !(hs && !g) && !i_flush;
      dh = d_valid && !(hs && g);
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_i_only();
    test_fairness();
    test_lock();
    test_full();
    test_flush();
    test_flush_collision();
    test_random();
    do_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
